// File: rtl/nes_pkg.sv
// Shared definitions for the iNES cartridge loader.
//   ines_state_t   : loader FSM states
//   INES_MAGIC     : "NES<EOF>" signature, byte 0 in the least significant byte
//   INES_*_BYTES   : default NROM-128 image geometry
//   ERR_*          : err_code values reported by the loader
//   state_flags()  : status outputs that go with each state
package nes_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_PRG,
    ST_CHR,
    ST_DONE,
    ST_ERROR
  } ines_state_t;

  localparam int unsigned INES_HDR_BYTES = 16;
  localparam int unsigned INES_PRG_BYTES = 16384;
  localparam int unsigned INES_CHR_BYTES = 8192;

  // Width of the file-offset counter; the largest image is 0x6010 bytes.
  localparam int unsigned CNT_W = 15;

  localparam logic [31:0] INES_MAGIC = 32'h1A53454E;

  localparam logic [1:0] ERR_NONE        = 2'd0;
  localparam logic [1:0] ERR_BAD_MAGIC   = 2'd1;
  localparam logic [1:0] ERR_UNSUPPORTED = 2'd2;

  typedef struct packed {
    logic in_ready;
    logic busy;
    logic done;
    logic err;
  } ines_flags_t;

  function automatic logic [7:0] magic_byte(input logic [1:0] idx);
    return INES_MAGIC[8*idx +: 8];
  endfunction

  function automatic ines_flags_t state_flags(input ines_state_t s);
    ines_flags_t f;
    f = '0;
    case (s)
      ST_HEADER, ST_PRG, ST_CHR: begin
        f.in_ready = 1'b1;
        f.busy     = 1'b1;
      end
      ST_DONE:  f.done = 1'b1;
      ST_ERROR: f.err  = 1'b1;
      default:  ;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/ines_header_check.sv
// Combinational validation of one iNES header byte.
//   index     : file offset of the byte being accepted
//   data      : the byte itself
//   mapper_lo : upper nibble of header byte 6, captured earlier (needed at byte 7)
//   ok        : byte is acceptable
//   code      : err_code to report when ok is low
module ines_header_check
  import nes_pkg::*;
(
  input  logic [CNT_W-1:0] index,
  input  logic [7:0]       data,
  input  logic [3:0]       mapper_lo,
  output logic             ok,
  output logic [1:0]       code
);

  always_comb begin
    ok   = 1'b1;
    code = ERR_NONE;
    case (index)
      15'd0, 15'd1, 15'd2, 15'd3: begin
        if (data != magic_byte(index[1:0])) begin
          ok   = 1'b0;
          code = ERR_BAD_MAGIC;
        end
      end
      // One 16 KiB PRG bank and one 8 KiB CHR bank only.
      15'd4, 15'd5: begin
        if (data != 8'h01) begin
          ok   = 1'b0;
          code = ERR_UNSUPPORTED;
        end
      end
      // Trainer present would shift every later offset.
      15'd6: begin
        if (data[2]) begin
          ok   = 1'b0;
          code = ERR_UNSUPPORTED;
        end
      end
      // Full mapper number is only known once byte 7 arrives.
      15'd7: begin
        if ({data[7:4], mapper_lo} != 8'h00) begin
          ok   = 1'b0;
          code = ERR_UNSUPPORTED;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ines_loader.sv
// iNES (NROM-128) image loader: streams a host file into cartridge ROM.
//   cpu_clk, rst        : clock, asynchronous active-high reset
//   start               : one-cycle pulse, begins a load from IDLE/DONE/ERROR
//   in_valid/in_data    : host byte stream in file order; in_ready accepts
//   prog/prog_ab/prog_di: one-cycle ROM write per accepted byte, address =
//                         file offset, issued one cycle after acceptance
//   busy/done/err       : load status levels
//   err_code            : 0 none, 1 bad magic, 2 unsupported format
module ines_loader
  import nes_pkg::*;
#(
  parameter int unsigned HDR_BYTES = INES_HDR_BYTES,
  parameter int unsigned PRG_BYTES = INES_PRG_BYTES,
  parameter int unsigned CHR_BYTES = INES_CHR_BYTES
) (
  input  logic        cpu_clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        prog,
  output logic [15:0] prog_ab,
  output logic [7:0]  prog_di,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code
);

  localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(HDR_BYTES - 1);
  localparam logic [CNT_W-1:0] PRG_LAST = CNT_W'(HDR_BYTES + PRG_BYTES - 1);
  localparam logic [CNT_W-1:0] CHR_LAST = CNT_W'(HDR_BYTES + PRG_BYTES + CHR_BYTES - 1);

  ines_state_t      state;
  ines_state_t      state_nxt;
  ines_flags_t      flags_nxt;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       mapper_lo;
  logic             accept;
  logic             restart;
  logic             hdr_ok;
  logic [1:0]       hdr_code;

  // in_ready is registered and only high in the loading states, so a byte
  // offered alongside a start pulse in IDLE is never taken.
  assign accept  = in_valid & in_ready;
  assign restart = start & ((state == ST_IDLE) | (state == ST_DONE) | (state == ST_ERROR));

  ines_header_check u_hdr (
    .index     (cnt),
    .data      (in_data),
    .mapper_lo (mapper_lo),
    .ok        (hdr_ok),
    .code      (hdr_code)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) state_nxt = ST_HEADER;
      end
      ST_HEADER: begin
        if (accept) begin
          if (!hdr_ok)               state_nxt = ST_ERROR;
          else if (cnt == HDR_LAST)  state_nxt = ST_PRG;
        end
      end
      ST_PRG: begin
        if (accept && (cnt == PRG_LAST)) state_nxt = ST_CHR;
      end
      ST_CHR: begin
        if (accept && (cnt == CHR_LAST)) state_nxt = ST_DONE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with it.
  assign flags_nxt = state_flags(state_nxt);

  always_ff @(posedge cpu_clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      mapper_lo <= '0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
      prog      <= 1'b0;
      prog_ab   <= '0;
      prog_di   <= '0;
    end else begin
      state                       <= state_nxt;
      {in_ready, busy, done, err} <= flags_nxt;

      // The offending header byte is still written; later bytes are not,
      // because in_ready drops together with the move to ERROR.
      prog <= accept;
      if (accept) begin
        prog_ab <= {{(16 - CNT_W){1'b0}}, cnt};
        prog_di <= in_data;
      end

      if (restart) begin
        cnt <= '0;
      end else if (accept) begin
        cnt <= cnt + 1'b1;
      end

      if ((state == ST_HEADER) && accept && (cnt == 15'd6)) begin
        mapper_lo <= in_data[7:4];
      end

      if (restart) begin
        err_code <= ERR_NONE;
      end else if ((state == ST_HEADER) && accept && !hdr_ok) begin
        err_code <= hdr_code;
      end
    end
  end

endmodule

// File: tb/tb_ines_loader.sv
module tb_ines_loader;

  // Reduced PRG/CHR sizes keep every scenario short; boundaries follow the
  // same header+PRG+CHR arithmetic as the full-size image.
  localparam int unsigned HDR = 16;
  localparam int unsigned PRG = 2048;
  localparam int unsigned CHR = 1024;
  localparam int unsigned TOT = HDR + PRG + CHR;

  logic        cpu_clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        prog;
  logic [15:0] prog_ab;
  logic [7:0]  prog_di;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;

  ines_loader #(
    .HDR_BYTES (HDR),
    .PRG_BYTES (PRG),
    .CHR_BYTES (CHR)
  ) dut (
    .cpu_clk  (cpu_clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .prog     (prog),
    .prog_ab  (prog_ab),
    .prog_di  (prog_di),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .err_code (err_code)
  );

  always #5 cpu_clk = ~cpu_clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [7:0]  file [TOT];
  logic [15:0] cap_ab [$];
  logic [7:0]  cap_di [$];
  int          idx;

  always @(negedge cpu_clk) begin
    if (prog) begin
      cap_ab.push_back(prog_ab);
      cap_di.push_back(prog_di);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void make_file(input bit ramp);
    logic [7:0] hdr [8];
    hdr = '{8'h4E, 8'h45, 8'h53, 8'h1A, 8'h01, 8'h01, 8'h00, 8'h00};
    for (int i = 0; i < int'(TOT); i++) begin
      if (i < 8)                file[i] = hdr[i];
      else if (i < int'(HDR))   file[i] = 8'h00;
      else if (ramp)            file[i] = 8'(i - int'(HDR));
      else                      file[i] = 8'($urandom);
    end
  endfunction

  // Reference: scan the header with the format rules; the first offending
  // byte is the last one written, otherwise the whole file is written.
  function automatic void expect_load(output int n_wr, output logic [1:0] code);
    logic [7:0] magic [4];
    magic = '{8'h4E, 8'h45, 8'h53, 8'h1A};
    n_wr = int'(TOT);
    code = 2'd0;
    for (int i = 0; i < int'(HDR); i++) begin
      if (i < 4) begin
        if (file[i] != magic[i]) code = 2'd1;
      end else if (i == 4 || i == 5) begin
        if (file[i] != 8'h01) code = 2'd2;
      end else if (i == 6) begin
        if (file[6][2]) code = 2'd2;
      end else if (i == 7) begin
        if (file[7][7:4] != 4'h0 || file[6][7:4] != 4'h0) code = 2'd2;
      end
      if (code != 2'd0) begin
        n_wr = i + 1;
        return;
      end
    end
  endfunction

  task automatic check_reset_outputs(input string name);
    check_eq({name, "/prog"},     32'(prog),     32'd0);
    check_eq({name, "/prog_ab"},  32'(prog_ab),  32'd0);
    check_eq({name, "/prog_di"},  32'(prog_di),  32'd0);
    check_eq({name, "/in_ready"}, 32'(in_ready), 32'd0);
    check_eq({name, "/busy"},     32'(busy),     32'd0);
    check_eq({name, "/done"},     32'(done),     32'd0);
    check_eq({name, "/err"},      32'(err),      32'd0);
    check_eq({name, "/err_code"}, 32'(err_code), 32'd0);
  endtask

  // mode 0: in_valid always high, 1: 3 cycles on / 3 off, 2: random gaps.
  // stop_at >= 0 abandons the load once that many bytes were consumed.
  // start_at >= 0 pulses start once mid-load at that offset.
  task automatic run_load(input string name, input int mode, input int stop_at, input int start_at);
    int         cyc;
    int         tail;
    int         exp_n;
    int         mism;
    int         lim;
    logic [1:0] exp_code;
    bit         mid_done;
    cyc = 0;
    tail = 0;
    mid_done = 1'b0;
    cap_ab.delete();
    cap_di.delete();
    idx = 0;

    // A byte offered together with start must not be consumed.
    @(negedge cpu_clk);
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = file[0];
    @(negedge cpu_clk);
    start = 1'b0;
    check_eq({name, "/busy_start"},  32'(busy),     32'd1);
    check_eq({name, "/ready_start"}, 32'(in_ready), 32'd1);
    check_eq({name, "/done_clr"},    32'(done),     32'd0);
    check_eq({name, "/err_clr"},     32'(err),      32'd0);
    check_eq({name, "/code_clr"},    32'(err_code), 32'd0);
    check_eq({name, "/no_early_wr"}, 32'(cap_ab.size()), 32'd0);

    while (cyc < 3 * int'(TOT) + 200) begin
      if (stop_at >= 0 && idx == stop_at) begin
        in_valid = 1'b0;
        return;
      end
      start = (start_at >= 0 && idx == start_at && !mid_done);
      if (start) mid_done = 1'b1;
      case (mode)
        0:       in_valid = 1'b1;
        1:       in_valid = ((cyc / 3) % 2) == 0;
        default: in_valid = ($urandom_range(0, 3) != 0);
      endcase
      in_data = in_valid ? ((idx < int'(TOT)) ? file[idx] : 8'hA5) : 8'($urandom);
      if (in_valid && in_ready) idx++;
      if (done || err) tail++;
      if (tail > 4) break;
      @(negedge cpu_clk);
      cyc++;
    end
    in_valid = 1'b0;
    start    = 1'b0;

    check_eq({name, "/finished"}, 32'(done | err), 32'd1);
    expect_load(exp_n, exp_code);
    check_eq({name, "/wr_count"}, 32'(cap_ab.size()), 32'(exp_n));
    check_eq({name, "/consumed"}, 32'(idx), 32'(exp_n));
    mism = 0;
    lim = (cap_ab.size() < exp_n) ? cap_ab.size() : exp_n;
    for (int i = 0; i < lim; i++) begin
      if (cap_ab[i] != 16'(i) || cap_di[i] != file[i]) mism++;
    end
    check_eq({name, "/wr_bad"},   32'(mism),     32'd0);
    check_eq({name, "/done"},     32'(done),     32'(exp_code == 2'd0));
    check_eq({name, "/err"},      32'(err),      32'(exp_code != 2'd0));
    check_eq({name, "/err_code"}, 32'(err_code), 32'(exp_code));
    check_eq({name, "/in_ready"}, 32'(in_ready), 32'd0);
    check_eq({name, "/busy"},     32'(busy),     32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    n_errors++;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] bitpos;
    int         k;

    repeat (3) @(negedge cpu_clk);
    check_reset_outputs("por");
    rst = 1'b0;
    @(negedge cpu_clk);
    check_eq("idle/in_ready", 32'(in_ready), 32'd0);

    // Valid file with ramp body, continuous stream.
    make_file(1'b1);
    run_load("ramp", 0, -1, -1);
    check_eq("ramp/last_ab", 32'((cap_ab.size() > 0) ? cap_ab[$] : 16'hFFFF), 32'(TOT - 1));
    check_eq("ramp/last_di", 32'((cap_di.size() > 0) ? cap_di[$] : 8'h00), 32'(8'(TOT - 1 - HDR)));

    // Header faults.
    make_file(1'b0); file[3] = 8'h1B; run_load("bad_magic", 0, -1, -1);
    make_file(1'b0); file[0] = 8'h4F; run_load("bad_magic0", 0, -1, -1);
    make_file(1'b0); file[6] = 8'h10; run_load("mapper_lo", 0, -1, -1);
    make_file(1'b0); file[4] = 8'h02; run_load("prg_banks", 0, -1, -1);
    make_file(1'b0); file[5] = 8'h00; run_load("chr_banks", 0, -1, -1);
    make_file(1'b0); file[6] = 8'h04; run_load("trainer", 0, -1, -1);
    make_file(1'b0); file[7] = 8'h30; run_load("mapper_hi", 0, -1, -1);

    // Same ramp file with in_valid toggling every 3 cycles.
    make_file(1'b1);
    run_load("gap3", 1, -1, -1);

    // Random single-bit header corruptions with random in_valid gaps.
    for (int r = 0; r < 6; r++) begin
      make_file(1'b0);
      k = $urandom_range(0, 7);
      bitpos = 3'($urandom_range(0, 7));
      file[k] = file[k] ^ (8'h01 << bitpos);
      run_load($sformatf("rand%0d_b%0d", r, k), 2, -1, -1);
    end

    // Reset in the middle of a load, then a full load.
    make_file(1'b0);
    run_load("pre_rst", 0, 'h200, -1);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    @(negedge cpu_clk);
    rst = 1'b0;
    cap_ab.delete();
    cap_di.delete();
    repeat (3) @(negedge cpu_clk);
    check_eq("rst_mid/no_pulse", 32'(cap_ab.size()), 32'd0);
    run_load("after_rst", 0, -1, -1);
    check_eq("after_rst/first_ab", 32'((cap_ab.size() > 0) ? cap_ab[0] : 16'hFFFF), 32'd0);

    // start mid-load is ignored.
    make_file(1'b0);
    run_load("mid_start", 0, -1, 'h100);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ines_loader.md
INES_LOADER -- requirements
Module: ines_loader

Interface
REQ-001 SHALL have parameter HDR_BYTES, default 16, iNES header length in bytes.
REQ-002 SHALL have parameter PRG_BYTES, default 16384, PRG image length (NROM-128).
REQ-003 SHALL have parameter CHR_BYTES, default 8192, CHR image length.
REQ-004 SHALL have port cpu_clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port start  input  1  one-cycle pulse to begin a load.
REQ-007 SHALL have port in_valid  input  1  host byte valid.
REQ-008 SHALL have port in_data  input  8  host byte, iNES file order.
REQ-009 SHALL have port in_ready  output  1  loader accepts byte this cycle.
REQ-010 SHALL have port prog  output  1  ROM write strobe, one cycle per byte.
REQ-011 SHALL have port prog_ab  output  16  ROM write address = file offset.
REQ-012 SHALL have port prog_di  output  8  ROM write data.
REQ-013 SHALL have port busy  output  1  load in progress.
REQ-014 SHALL have port done  output  1  full image written, level until next start.
REQ-015 SHALL have port err  output  1  load aborted, level until next start.
REQ-016 SHALL have port err_code  output  2  0 none, 1 bad magic, 2 unsupported format.

Function
REQ-017 SHALL implement states IDLE, HEADER, PRG, CHR, DONE, ERROR.
REQ-018 SHALL accept a byte only on cycles with in_valid && in_ready; in_ready = 1 only in HEADER, PRG, CHR.
REQ-019 SHALL, on start in IDLE, DONE or ERROR: clear byte counter, done, err, err_code; enter HEADER next cycle.
REQ-020 SHALL ignore start while in HEADER, PRG or CHR.
REQ-021 SHALL, for every accepted byte (header included), drive prog=1, prog_ab=counter value at acceptance, prog_di=byte, exactly one cycle after acceptance (latency 1).
REQ-022 SHALL increment a 15-bit byte counter per accepted byte; prog_ab is zero-extended counter.
REQ-023 SHALL check header bytes 0..3 equal 4E,45,53,1A on acceptance; mismatch -> ERROR, err_code=1.
REQ-024 SHALL require byte4 = 01, byte5 = 01, byte6 bit2 (trainer) = 0, mapper {byte7[7:4],byte6[7:4]} = 0; else -> ERROR, err_code=2 (mapper checked on acceptance of byte 7).
REQ-025 SHALL still emit the prog write of the offending byte; no further writes after entering ERROR.
REQ-026 SHALL go HEADER->PRG after byte HDR_BYTES-1, PRG->CHR after offset 0x400F, CHR->DONE after offset 0x600F (total 0x6010 writes).
REQ-027 SHALL keep in_ready=0 in DONE and ERROR; extra bytes are not consumed.
REQ-028 SHALL have busy=1 exactly in HEADER, PRG, CHR; done=1 only in DONE; err=1 only in ERROR.
REQ-029 SHALL tolerate arbitrary in_valid gaps with no effect on counter or prog.
REQ-030 SHALL not accept a byte presented in the same cycle as a start in IDLE.

Reset
REQ-031 SHALL on rst: state IDLE, counter 0, prog 0, prog_ab 0, prog_di 0, in_ready 0, busy 0, done 0, err 0, err_code 0.
REQ-032 SHALL on rst mid-load abort immediately, without a pending prog pulse after release.

Structure
REQ-033 SHALL take state enum, iNES magic constant, header/PRG/CHR sizes and err_code values from shared package nes_pkg.
REQ-034 SHALL place header byte validation in sub-module ines_header_check (combinational: index, byte -> ok, code).

Verification
REQ-035 Valid file 4E 45 53 1A 01 01 00 00 +8x00 + 24576 ramp bytes, in_valid always 1 -> 0x6010 prog pulses, last prog_ab=0x600F, done=1 one cycle after last write.
REQ-036 Byte 3 = 1B -> 4 prog pulses (0x0000..0x0003), err=1, err_code=1, in_ready=0 thereafter.
REQ-037 Byte 6 = 10 (mapper 1) -> after byte 7, err_code=2; byte 4 = 02 -> err_code=2 after byte 4.
REQ-038 Valid file with in_valid toggling every 3 cycles -> identical prog_ab/prog_di sequence to REQ-035.
REQ-039 rst asserted at offset 0x2000 then start + valid file -> complete load, first prog_ab=0x0000, done=1.
REQ-040 start pulsed at offset 0x100 mid-load -> ignored, load completes with 0x6010 writes.
